// File: rtl/lane_valid_scheduler.sv
// Phase-locked serial/parallel valid sequencer for the 1-to-N / N-to-1 lane converter.
// Optional burst auto-stop: define LANE_VALID_SCHED_BURST_LIMIT_EN to add i_burst_len.
module lane_valid_scheduler #(
  parameter int N_LANES        = 20,
  parameter int COUNT_SCALE    = 2,
  parameter int NB_LANE_IDX    = $clog2(N_LANES),
  parameter int NB_GROUP_COUNT = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_start,
  input  logic                      i_stop,
`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
  input  logic [NB_GROUP_COUNT-1:0] i_burst_len,
`endif
  output logic                      o_valid_serial,
  output logic [NB_LANE_IDX-1:0]    o_lane_idx,
  output logic                      o_valid_parallel,
  output logic [NB_GROUP_COUNT-1:0] o_group_count,
  output logic                      o_busy
);

  localparam int NB_PRE = (COUNT_SCALE > 1) ? $clog2(COUNT_SCALE) : 1;
  localparam logic [NB_PRE-1:0]      PRE_LAST  = NB_PRE'(COUNT_SCALE - 1);
  localparam logic [NB_LANE_IDX-1:0] LANE_LAST = NB_LANE_IDX'(N_LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  state_t                    state;
  logic [NB_PRE-1:0]         pre;
  logic [NB_LANE_IDX-1:0]    lane_idx;
  logic [NB_GROUP_COUNT-1:0] group_count;
  logic                      par_pend;

  logic active, ser_fire, last_fire, par_fire, at_boundary, burst_done;

  // Strobes are gated in-cycle by enable and reset; everything behind them is registered.
  always_comb begin
    active      = (state == S_RUN) || (state == S_DRAIN);
    ser_fire    = i_enable && !i_reset && active && (pre == PRE_LAST);
    last_fire   = ser_fire && (lane_idx == LANE_LAST);
    par_fire    = i_enable && !i_reset && par_pend;
    // A stop here leaves no partial group: either nothing of the next group has
    // been strobed yet, or this cycle completes the current one.
    at_boundary = ((lane_idx == '0) && (pre == '0) && !ser_fire) || last_fire;
  end

`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
  logic [NB_GROUP_COUNT-1:0] burst_len_q;
  logic [NB_GROUP_COUNT-1:0] groups_done;
  assign burst_done = last_fire && (burst_len_q != '0) &&
                      ((groups_done + NB_GROUP_COUNT'(1)) == burst_len_q);
`else
  assign burst_done = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_IDLE;
      pre         <= '0;
      lane_idx    <= '0;
      group_count <= '0;
      par_pend    <= 1'b0;
      o_busy      <= 1'b0;
`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
      burst_len_q <= '0;
      groups_done <= '0;
`endif
    end else if (i_enable) begin
      if (par_pend) begin
        group_count <= group_count + NB_GROUP_COUNT'(1);
        par_pend    <= 1'b0;
      end
      if (last_fire) par_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            state  <= S_ARM;
            o_busy <= 1'b1;
          end
        end
        S_ARM: begin
          pre      <= '0;
          lane_idx <= '0;
          state    <= S_RUN;
`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
          burst_len_q <= i_burst_len;
          groups_done <= '0;
`endif
        end
        S_RUN, S_DRAIN: begin
          pre <= (pre == PRE_LAST) ? '0 : pre + NB_PRE'(1);
          if (ser_fire) lane_idx <= (lane_idx == LANE_LAST) ? '0 : lane_idx + NB_LANE_IDX'(1);
`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
          if (last_fire) groups_done <= groups_done + NB_GROUP_COUNT'(1);
`endif
          if ((state == S_RUN) && i_stop) begin
            if (at_boundary) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state  <= S_DRAIN;
            end
          end else if (last_fire && ((state == S_DRAIN) || burst_done)) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid_serial   = ser_fire;
  assign o_lane_idx       = lane_idx;
  assign o_valid_parallel = par_fire;
  assign o_group_count    = group_count;

endmodule

// File: tb/tb_lane_valid_scheduler.sv
// Scoreboard bench: a 20-lane/scale-2 and a 4-lane/scale-1/2-bit-count scheduler share stimulus.
module tb_lane_valid_scheduler;

  logic tb_clock = 1'b0;
  always #5 tb_clock = ~tb_clock;

`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int NL  [2] = '{20, 4};
  localparam int CSC [2] = '{2, 1};
  localparam int MSK [2] = '{65535, 3};

  logic        rst, en, st, sp;
  logic [15:0] bl;

  logic        ser_b, par_b, busy_b;
  logic [4:0]  lane_b;
  logic [15:0] gc_b;
  logic        ser_s, par_s, busy_s;
  logic [1:0]  lane_s;
  logic [1:0]  gc_s;

  lane_valid_scheduler u_big (
    .i_clock(tb_clock), .i_reset(rst), .i_enable(en), .i_start(st), .i_stop(sp),
`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
    .i_burst_len(bl),
`endif
    .o_valid_serial(ser_b), .o_lane_idx(lane_b), .o_valid_parallel(par_b),
    .o_group_count(gc_b), .o_busy(busy_b)
  );

  lane_valid_scheduler #(.N_LANES(4), .COUNT_SCALE(1), .NB_GROUP_COUNT(2)) u_small (
    .i_clock(tb_clock), .i_reset(rst), .i_enable(en), .i_start(st), .i_stop(sp),
`ifdef LANE_VALID_SCHED_BURST_LIMIT_EN
    .i_burst_len(bl[1:0]),
`endif
    .o_valid_serial(ser_s), .o_lane_idx(lane_s), .o_valid_parallel(par_s),
    .o_group_count(gc_s), .o_busy(busy_s)
  );

  typedef struct {int cyc; int val;} ev_t;
  ev_t serq [2][$];
  ev_t parq [2][$];

  int cyc = 0;
  always @(posedge tb_clock) cyc <= cyc + 1;

  int total = 0, bad = 0;
  bit mon_on = 0, busy_chk = 0;

  // Reference model: time counted in enabled RUN cycles; strobe k lands at
  // enabled cycle CS*(k+1)-1 and addresses lane k mod N.
  int mode [2], s [2], stop_q [2], burst_q [2], pend [2], gcnt [2], exp_busy [2];

  int sn_ser_b, sn_lane_b, sn_par_b, sn_gc_b, sn_busy_b, sn_busy_s;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model(int d, int c);
    int q, lane, ble;
    exp_busy[d] = (mode[d] != 0) ? 1 : 0;
    if (rst) begin
      mode[d] = 0; pend[d] = 0; gcnt[d] = 0;
      return;
    end
    if (!en) return;
    if (pend[d] != 0) begin
      parq[d].push_back(ev_t'{c, gcnt[d]});
      pend[d] = 0;
      gcnt[d] = (gcnt[d] + 1) & MSK[d];
    end
    case (mode[d])
      0: if (st) mode[d] = 1;
      1: begin
        ble        = BURST ? (int'(bl) & MSK[d]) : 0;
        mode[d]    = 2;
        s[d]       = 0;
        stop_q[d]  = -1;
        burst_q[d] = (ble != 0) ? ble * NL[d] : -1;
      end
      default: begin
        q = (s[d] + 1) / CSC[d];
        if ((s[d] + 1) % CSC[d] == 0) begin
          lane = (q - 1) % NL[d];
          serq[d].push_back(ev_t'{c, lane});
          if (lane == NL[d] - 1) pend[d] = 1;
        end
        if (sp && stop_q[d] < 0)
          stop_q[d] = ((q % NL[d] == 0) && ((s[d] % CSC[d] == 0) || (s[d] % CSC[d] == CSC[d] - 1)))
                      ? q : (q / NL[d] + 1) * NL[d];
        if (q == stop_q[d] || q == burst_q[d]) mode[d] = 0;
        else s[d]++;
      end
    endcase
  endtask

  task automatic drv(bit r, bit e, bit a, bit p);
    rst = r; en = e; st = a; sp = p;
    model(0, cyc);
    model(1, cyc);
    @(negedge tb_clock);
    sn_ser_b = int'(ser_b); sn_lane_b = int'(lane_b); sn_par_b = int'(par_b);
    sn_gc_b = int'(gc_b); sn_busy_b = int'(busy_b); sn_busy_s = int'(busy_s);
    if (busy_chk) begin
      chk("busy_big", sn_busy_b, exp_busy[0]);
      chk("busy_small", sn_busy_s, exp_busy[1]);
    end
    @(posedge tb_clock);
    #1;
  endtask

  // Monitor: every strobe must match the head of its queue in cycle and payload.
  always @(negedge tb_clock) begin
    bit sv, pv;
    int lv, gv;
    ev_t ev;
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        sv = (d == 0) ? ser_b : ser_s;
        pv = (d == 0) ? par_b : par_s;
        lv = (d == 0) ? int'(lane_b) : int'(lane_s);
        gv = (d == 0) ? int'(gc_b) : int'(gc_s);
        while (serq[d].size() > 0 && serq[d][0].cyc < cyc) begin
          ev = serq[d].pop_front();
          total++; bad++;
          $display("FAIL serial_missing dut%0d: got none expected lane %0d at cycle %0d", d, ev.val, ev.cyc);
        end
        while (parq[d].size() > 0 && parq[d][0].cyc < cyc) begin
          ev = parq[d].pop_front();
          total++; bad++;
          $display("FAIL parallel_missing dut%0d: got none expected strobe at cycle %0d", d, ev.cyc);
        end
        if (sv) begin
          if (serq[d].size() == 0 || serq[d][0].cyc != cyc) begin
            total++; bad++;
            $display("FAIL serial_unexpected dut%0d: got lane %0d expected no strobe at cycle %0d", d, lv, cyc);
          end else begin
            ev = serq[d].pop_front();
            chk($sformatf("serial_lane dut%0d", d), lv, ev.val);
          end
        end
        if (pv) begin
          if (parq[d].size() == 0 || parq[d][0].cyc != cyc) begin
            total++; bad++;
            $display("FAIL parallel_unexpected dut%0d: got strobe expected none at cycle %0d", d, cyc);
          end else begin
            ev = parq[d].pop_front();
            chk($sformatf("group_count dut%0d", d), gv, ev.val);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; st = 1'b0; sp = 1'b0; bl = '0;
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; s[d] = 0; stop_q[d] = -1; burst_q[d] = -1; pend[d] = 0; gcnt[d] = 0; exp_busy[d] = 0;
    end
    @(posedge tb_clock);
    #1;
    drv(1, 1, 0, 0);
    drv(1, 1, 0, 0);
    busy_chk = 1; mon_on = 1;

    // Start, two groups, freeze across the lane-19 strobe, then stop mid-group.
    drv(0, 1, 1, 0);
    chk("reset_serial", sn_ser_b, 0);
    chk("reset_parallel", sn_par_b, 0);
    chk("reset_group_count", sn_gc_b, 0);
    chk("reset_busy", sn_busy_b, 0);
    for (int k = 1; k <= 130; k++) begin
      drv(0, !(k >= 81 && k <= 85), 0, k == 102);
      case (k)
        1:   chk("arm_busy", sn_busy_b, 1);
        2:   chk("run_no_strobe_yet", sn_ser_b, 0);
        3:   begin chk("first_serial", sn_ser_b, 1); chk("first_lane", sn_lane_b, 0); end
        41:  begin chk("lane19_serial", sn_ser_b, 1); chk("lane19_idx", sn_lane_b, 19); end
        42:  begin chk("first_parallel", sn_par_b, 1); chk("par_busy", sn_busy_b, 1); end
        43:  chk("group_count_1", sn_gc_b, 1);
        81:  chk("disabled_serial", sn_ser_b, 0);
        86:  begin chk("resumed_serial", sn_ser_b, 1); chk("resumed_lane", sn_lane_b, 19); end
        87:  chk("resumed_parallel", sn_par_b, 1);
        110: chk("drain_busy", sn_busy_b, 1);
        126: begin chk("drain_last_serial", sn_ser_b, 1); chk("drain_last_lane", sn_lane_b, 19); end
        127: begin chk("drain_parallel", sn_par_b, 1); chk("drain_busy_low", sn_busy_b, 0); end
        128: begin chk("drain_group_count", sn_gc_b, 3); chk("drain_quiet", sn_ser_b, 0); end
        default: ;
      endcase
    end

    // Restart, reset on lane 10 of the second group, restart again.
    drv(0, 1, 1, 0);
    for (int k = 1; k <= 67; k++) begin
      drv(k == 63, 1, k == 64, 0);
      case (k)
        63: chk("reset_cycle_lane10_gated", sn_ser_b, 0);
        64: begin
          chk("post_reset_serial", sn_ser_b, 0);
          chk("post_reset_parallel", sn_par_b, 0);
          chk("post_reset_gc", sn_gc_b, 0);
          chk("post_reset_busy", sn_busy_b, 0);
        end
        67: begin chk("restart_serial", sn_ser_b, 1); chk("restart_lane", sn_lane_b, 0); end
        default: ;
      endcase
    end

    // Randomized traffic.
    repeat (6000) begin
      bl = 16'($urandom_range(0, 3));
      drv($urandom_range(0, 399) == 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0);
    end

    // Wind down: two stop pulses cover an ARM cycle swallowing the first.
    drv(0, 1, 0, 1);
    drv(0, 1, 0, 1);
    for (int i = 0; i < 200 && (sn_busy_b != 0 || sn_busy_s != 0); i++) drv(0, 1, 0, 0);
    chk("wind_down_idle", sn_busy_b | sn_busy_s, 0);
    repeat (4) drv(0, 1, 0, 0);
    chk("final_gc_big", int'(gc_b), gcnt[0]);
    chk("final_gc_small", int'(gc_s), gcnt[1]);
    chk("serial_queue_empty", serq[0].size() + serq[1].size(), 0);
    chk("parallel_queue_empty", parq[0].size() + parq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
